loader_mem_responder: RTL and testbench
=======================================

Name: loader_mem_responder

Overview:
- Responder end of the ROM/image loader write handshake.
- Accepts one byte at a time from the host-side loader (address, data, level-held write strobe). Turns each byte into a byte-enabled 16-bit write request to the SDRAM arbiter, then acknowledges the loader.
- Sits inside the PC88 top, between the loader port group and the SDRAM controller's client port.
- Also tracks load progress: byte count, 8-bit checksum, out-of-range drops, and a loaded flag.

Parameters:
- BASE, 24'h000000, SDRAM byte address at which loader address 0 is placed.
- LIMIT, 19'h7FFFF, highest accepted loader address; bytes above it are acknowledged but not written.
- ADR_W, 23, width of the SDRAM word address (byte address >> 1).

Ports:
- clk21m  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- LOADER_ADR  in  19  byte address of the current loader byte.
- LOADER_WDAT  in  8  data of the current loader byte.
- LOADER_OE  in  1  loader session active; WR is ignored while low.
- LOADER_WR  in  1  level write request; held high until the loader sees an ACK rising edge.
- LOADER_ACK  out  1  acknowledge; 4-phase.
- LOADER_DONE  in  1  loader finished; sticky from the host side.
- mem_req  out  1  write request to the SDRAM arbiter; held until mem_ack.
- mem_ack  in  1  single-cycle pulse; write accepted.
- mem_adr  out  ADR_W  SDRAM word address.
- mem_wdat  out  16  write data; byte replicated in both halves.
- mem_be  out  2  byte enables; [0] = even byte, [1] = odd byte.
- busy  out  1  FSM not in IDLE or LOADED.
- loaded  out  1  load complete; core may leave reset.
- byte_cnt  out  20  number of bytes acknowledged.
- csum  out  8  modulo-256 sum of the bytes actually written.
- drop_err  out  1  sticky; at least one byte was above LIMIT.

Behaviour:
- Reset (rstn=0, async) forces:
  - state=IDLE;
  - LOADER_ACK=0, mem_req=0, mem_adr=0, mem_wdat=0, mem_be=0;
  - busy=0, loaded=0, byte_cnt=0, csum=0, drop_err=0.
  - Reset mid-transaction abandons the pending mem_req with no completion. The arbiter must tolerate a dropped request.
- States: IDLE, REQ, ACK, LOADED.
- IDLE:
  - If LOADER_OE=1 and LOADER_WR=1: latch LOADER_ADR and LOADER_WDAT in that cycle.
  - If adr<=LIMIT:
    - byte address = BASE + adr, 24-bit, wraps mod 2^24;
    - mem_adr = byte address[ADR_W:1];
    - mem_be = byte address[0] ? 2'b10 : 2'b01;
    - mem_wdat = {WDAT, WDAT};
    - mem_req=1; next state REQ.
  - Else: drop_err<=1; next state ACK directly, with no memory write and csum unchanged.
  - If LOADER_DONE=1 and LOADER_WR=0: next state LOADED.
  - If WR and DONE are both high, WR wins; DONE is re-evaluated on the next return to IDLE.
- REQ:
  - mem_req, mem_adr, mem_wdat and mem_be are held stable.
  - On mem_ack=1:
    - mem_req<=0, mem_be<=0;
    - csum<=csum+WDAT (8-bit wrap);
    - next state ACK.
  - mem_ack outside REQ is ignored.
- ACK:
  - LOADER_ACK=1 from the first cycle in ACK.
  - byte_cnt increments once on entry; saturates at 20'hFFFFF.
  - Stays in ACK while LOADER_WR=1.
  - When LOADER_WR=0: LOADER_ACK<=0 and next state IDLE. LOADER_ACK is therefore high for at least 1 cycle.
  - A new byte is never accepted until ACK has returned low for one cycle in IDLE.
- Latency: WR high in IDLE → mem_req high next cycle. mem_ack → LOADER_ACK high the following cycle.
  - Minimum loop with mem_ack in the cycle after req: WR rise→ACK rise = 3 cycles.
- LOADER_OE falling while in REQ or ACK: the current transaction completes normally. OE is sampled only in IDLE.
- LOADED:
  - loaded=1, busy=0.
  - All loader inputs are ignored; absorbing until reset.
- busy=1 in REQ and ACK only.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Single byte: adr=0x00010, WDAT=0xA5, BASE=0, mem_ack 2 cycles after req →
  - mem_adr=0x8, mem_be=01, mem_wdat=0xA5A5;
  - LOADER_ACK rises 1 cycle after mem_ack and falls 1 cycle after WR drops;
  - byte_cnt=1, csum=0xA5.
- Odd address: adr=0x00011, WDAT=0x3C, BASE=24'h100000 → mem_adr=0x080008, mem_be=10.
- Stream of 256 bytes 0x00..0xFF, random mem_ack delay 1-10 → byte_cnt=256, csum=0x80, each request written exactly once.
- LIMIT=0x0FFFF, byte at 0x10000 → no mem_req, ACK still completes, drop_err=1, csum unchanged.
- Assert rstn=0 while in REQ → all outputs 0 immediately (async). After release, the next WR produces a fresh request.
- LOADER_DONE=1 with WR low → loaded=1 within 1 cycle. A subsequent WR → no mem_req, no ACK.

Source files
------------

// File: rtl/loader_mem_responder.sv
`timescale 1ns/1ps
// loader_mem_responder
// Responder side of the ROM/image loader byte handshake. Each loader byte
// becomes one byte-enabled 16-bit write to the SDRAM arbiter, after which the
// loader is acknowledged with a 4-phase ACK. Load progress is tracked too:
// bytes acknowledged, checksum of the bytes written, out-of-range drops, and a
// loaded flag that releases the core once the host reports completion.
module loader_mem_responder #(
    parameter logic [23:0] BASE  = 24'h000000,
    parameter logic [18:0] LIMIT = 19'h7FFFF,
    parameter int          ADR_W = 23
) (
    input  logic             clk21m,
    input  logic             rstn,
    input  logic [18:0]      LOADER_ADR,
    input  logic [7:0]       LOADER_WDAT,
    input  logic             LOADER_OE,
    input  logic             LOADER_WR,
    output logic             LOADER_ACK,
    input  logic             LOADER_DONE,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [ADR_W-1:0] mem_adr,
    output logic [15:0]      mem_wdat,
    output logic [1:0]       mem_be,
    output logic             busy,
    output logic             loaded,
    output logic [19:0]      byte_cnt,
    output logic [7:0]       csum,
    output logic             drop_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACK    = 2'd2,
        LOADED = 2'd3
    } state_t;

    state_t state;

    // Loader address relocated into SDRAM byte space; wraps modulo 2^24.
    logic [23:0] byte_adr;
    assign byte_adr = BASE + {5'd0, LOADER_ADR};

    // Handshake FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk21m or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            LOADER_ACK <= 1'b0;
            mem_req    <= 1'b0;
            mem_adr    <= '0;
            mem_wdat   <= '0;
            mem_be     <= '0;
            busy       <= 1'b0;
            loaded     <= 1'b0;
            byte_cnt   <= '0;
            csum       <= '0;
            drop_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A pending write takes priority over DONE; DONE is seen
                    // again the next time the FSM is idle.
                    if (LOADER_OE && LOADER_WR) begin
                        busy <= 1'b1;
                        if (LOADER_ADR <= LIMIT) begin
                            mem_adr  <= byte_adr[ADR_W:1];
                            mem_be   <= byte_adr[0] ? 2'b10 : 2'b01;
                            mem_wdat <= {LOADER_WDAT, LOADER_WDAT};
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end else begin
                            // Out of range: acknowledge without writing.
                            drop_err   <= 1'b1;
                            LOADER_ACK <= 1'b1;
                            if (byte_cnt != 20'hFFFFF)
                                byte_cnt <= byte_cnt + 20'd1;
                            state      <= ACK;
                        end
                    end else if (LOADER_DONE && !LOADER_WR) begin
                        loaded <= 1'b1;
                        state  <= LOADED;
                    end
                end
                REQ: begin
                    // Request fields stay frozen until the arbiter accepts.
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_be     <= 2'b00;
                        csum       <= csum + mem_wdat[7:0];
                        LOADER_ACK <= 1'b1;
                        if (byte_cnt != 20'hFFFFF)
                            byte_cnt <= byte_cnt + 20'd1;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    // Hold ACK until the loader withdraws its write strobe.
                    if (!LOADER_WR) begin
                        LOADER_ACK <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                LOADED: begin
                    // Absorbing: loader inputs are ignored until reset.
                    loaded <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loader_mem_responder.sv
`timescale 1ns/1ps
// Directed bench for loader_mem_responder. Instance u_a uses default
// parameters; u_b relocates to 0x100000 and limits addresses to 0x0FFFF.
module tb_loader_mem_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [18:0] ladr = '0;
    logic [7:0]  lwdat = '0;
    logic        loe = 1'b1;
    logic        lwr = 1'b0;
    logic        ldone = 1'b0;
    logic        ack_drv = 1'b0;
    logic        sel = 1'b0;

    logic        ack_a, req_a, busy_a, loaded_a, drop_a;
    logic [22:0] adr_a;
    logic [15:0] wdat_a;
    logic [1:0]  be_a;
    logic [19:0] cnt_a;
    logic [7:0]  csum_a;
    logic        ack_b, req_b, busy_b, loaded_b, drop_b;
    logic [22:0] adr_b;
    logic [15:0] wdat_b;
    logic [1:0]  be_b;
    logic [19:0] cnt_b;
    logic [7:0]  csum_b;
    logic        mem_ack_a, mem_ack_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign mem_ack_a = ack_drv & ~sel;
    assign mem_ack_b = ack_drv & sel;

    // Outputs of the instance currently under test.
    logic        cur_ack, cur_req, cur_busy, cur_loaded, cur_drop;
    logic [22:0] cur_adr;
    logic [15:0] cur_wdat;
    logic [1:0]  cur_be;
    logic [19:0] cur_cnt;
    logic [7:0]  cur_csum;
    assign cur_ack    = sel ? ack_b    : ack_a;
    assign cur_req    = sel ? req_b    : req_a;
    assign cur_busy   = sel ? busy_b   : busy_a;
    assign cur_loaded = sel ? loaded_b : loaded_a;
    assign cur_drop   = sel ? drop_b   : drop_a;
    assign cur_adr    = sel ? adr_b    : adr_a;
    assign cur_wdat   = sel ? wdat_b   : wdat_a;
    assign cur_be     = sel ? be_b     : be_a;
    assign cur_cnt    = sel ? cnt_b    : cnt_a;
    assign cur_csum   = sel ? csum_b   : csum_a;

    loader_mem_responder u_a (
        .clk21m(clk), .rstn(rstn), .LOADER_ADR(ladr), .LOADER_WDAT(lwdat),
        .LOADER_OE(loe), .LOADER_WR(lwr), .LOADER_ACK(ack_a), .LOADER_DONE(ldone),
        .mem_req(req_a), .mem_ack(mem_ack_a), .mem_adr(adr_a), .mem_wdat(wdat_a),
        .mem_be(be_a), .busy(busy_a), .loaded(loaded_a), .byte_cnt(cnt_a),
        .csum(csum_a), .drop_err(drop_a)
    );

    loader_mem_responder #(.BASE(24'h100000), .LIMIT(19'h0FFFF), .ADR_W(23)) u_b (
        .clk21m(clk), .rstn(rstn), .LOADER_ADR(ladr), .LOADER_WDAT(lwdat),
        .LOADER_OE(loe), .LOADER_WR(lwr), .LOADER_ACK(ack_b), .LOADER_DONE(ldone),
        .mem_req(req_b), .mem_ack(mem_ack_b), .mem_adr(adr_b), .mem_wdat(wdat_b),
        .mem_be(be_b), .busy(busy_b), .loaded(loaded_b), .byte_cnt(cnt_b),
        .csum(csum_b), .drop_err(drop_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; lwr = 1'b0; ldone = 1'b0; ack_drv = 1'b0; loe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One loader byte: raise WR, answer mem_req after dly cycles, drop WR on
    // ACK, wait for ACK to fall. Latencies are counted in cycles from WR rise.
    task automatic loader_write(input logic [18:0] a, input logic [7:0] d, input int dly,
                                output int req_lat, output int ack_lat, output int fall_lat,
                                output logic [22:0] cap_adr, output logic [15:0] cap_wdat,
                                output logic [1:0] cap_be, output int writes, output bit tmo);
        int  cyc;
        bit  seen_req;
        bit  got_ack;
        req_lat = -1; ack_lat = -1; fall_lat = -1; writes = 0; tmo = 1'b0;
        cap_adr = '0; cap_wdat = '0; cap_be = '0;
        seen_req = 1'b0; got_ack = 1'b0; cyc = 0;
        @(negedge clk);
        ladr = a; lwdat = d; lwr = 1'b1;
        while (!got_ack && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ack_drv = 1'b0;
            if (seen_req && cur_req && cyc > req_lat + dly) writes++;
            if (cur_ack) begin
                got_ack = 1'b1;
                ack_lat = cyc;
            end else begin
                if (cur_req && !seen_req) begin
                    seen_req = 1'b1; req_lat = cyc;
                    cap_adr = cur_adr; cap_wdat = cur_wdat; cap_be = cur_be;
                end
                if (seen_req && cyc == req_lat + dly) begin
                    ack_drv = 1'b1;
                    writes++;
                end
            end
        end
        ack_drv = 1'b0;
        lwr = 1'b0;
        if (!got_ack) tmo = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!cur_ack) begin
                fall_lat = k;
                break;
            end
        end
        $display("[TB] wr adr=%05h dat=%02h dly=%0d req_lat=%0d ack_lat=%0d mem_adr=%06h be=%b",
                 a, d, dly, req_lat, ack_lat, cap_adr, cap_be);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        tests_run++; if (ack_a !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0", ack_a); end
        tests_run++; if (req_a !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%b exp=0", req_a); end
        tests_run++; if (adr_a !== 23'd0 || wdat_a !== 16'd0 || be_a !== 2'd0) begin tests_failed++; $display("FAIL reset_memfields got adr=%h wdat=%h be=%b exp all 0", adr_a, wdat_a, be_a); end
        tests_run++; if (busy_a !== 1'b0 || loaded_a !== 1'b0 || drop_a !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got busy=%b loaded=%b drop=%b exp 0", busy_a, loaded_a, drop_a); end
        tests_run++; if (cnt_a !== 20'd0 || csum_a !== 8'd0) begin tests_failed++; $display("FAIL reset_counters got cnt=%h csum=%h exp 0", cnt_a, csum_a); end
    endtask

    task automatic test_single_byte();
        int rl, al, fl, wr; logic [22:0] ca; logic [15:0] cw; logic [1:0] cb; bit to;
        sel = 1'b0;
        do_reset();
        loader_write(19'h00010, 8'hA5, 2, rl, al, fl, ca, cw, cb, wr, to);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL single_timeout got=%b exp=0", to); end
        tests_run++; if (rl !== 1) begin tests_failed++; $display("FAIL single_req_lat got=%0d exp=1", rl); end
        tests_run++; if (ca !== 23'h8 || cb !== 2'b01 || cw !== 16'hA5A5) begin tests_failed++; $display("FAIL single_fields got adr=%h be=%b wdat=%h exp 8/01/a5a5", ca, cb, cw); end
        tests_run++; if (al !== 4) begin tests_failed++; $display("FAIL single_ack_rise got=%0d exp=4", al); end
        tests_run++; if (fl !== 1) begin tests_failed++; $display("FAIL single_ack_fall got=%0d exp=1", fl); end
        tests_run++; if (wr !== 1) begin tests_failed++; $display("FAIL single_writes got=%0d exp=1", wr); end
        tests_run++; if (cnt_a !== 20'd1 || csum_a !== 8'hA5) begin tests_failed++; $display("FAIL single_progress got cnt=%h csum=%h exp 1/a5", cnt_a, csum_a); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after got=%b exp=0", busy_a); end
        // Shortest loop: mem_ack in the cycle after req gives WR->ACK of 3.
        loader_write(19'h00002, 8'h01, 1, rl, al, fl, ca, cw, cb, wr, to);
        tests_run++; if (al !== 3) begin tests_failed++; $display("FAIL min_loop got=%0d exp=3", al); end
        tests_run++; if (cnt_a !== 20'd2 || csum_a !== 8'hA6) begin tests_failed++; $display("FAIL min_loop_progress got cnt=%h csum=%h exp 2/a6", cnt_a, csum_a); end
    endtask

    task automatic test_odd_address();
        int rl, al, fl, wr; logic [22:0] ca; logic [15:0] cw; logic [1:0] cb; bit to;
        sel = 1'b1;
        do_reset();
        loader_write(19'h00011, 8'h3C, 1, rl, al, fl, ca, cw, cb, wr, to);
        tests_run++; if (ca !== 23'h080008 || cb !== 2'b10 || cw !== 16'h3C3C) begin tests_failed++; $display("FAIL odd_fields got adr=%h be=%b wdat=%h exp 080008/10/3c3c", ca, cb, cw); end
        tests_run++; if (csum_b !== 8'h3C || to !== 1'b0) begin tests_failed++; $display("FAIL odd_csum got csum=%h tmo=%b exp 3c/0", csum_b, to); end
    endtask

    task automatic test_stream();
        int rl, al, fl, wr, bad; logic [22:0] ca; logic [15:0] cw; logic [1:0] cb; bit to;
        logic [7:0] b;
        sel = 1'b0;
        do_reset();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            loader_write({11'd0, b}, b, int'($urandom_range(1, 10)), rl, al, fl, ca, cw, cb, wr, to);
            if (ca !== {15'd0, b[7:1]} || cb !== (b[0] ? 2'b10 : 2'b01) || cw !== {b, b} || wr !== 1 || to !== 1'b0) begin
                bad++;
                $display("FAIL stream_byte i=%0d got adr=%h be=%b wdat=%h writes=%0d exp adr=%h", i, ca, cb, cw, wr, b[7:1]);
            end
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL stream_bytes got_bad=%0d exp=0", bad); end
        tests_run++; if (cnt_a !== 20'd256) begin tests_failed++; $display("FAIL stream_cnt got=%0d exp=256", cnt_a); end
        tests_run++; if (csum_a !== 8'h80) begin tests_failed++; $display("FAIL stream_csum got=%h exp=80", csum_a); end
    endtask

    task automatic test_drop();
        int rl, al, fl, wr; logic [22:0] ca; logic [15:0] cw; logic [1:0] cb; bit to;
        sel = 1'b1;
        do_reset();
        loader_write(19'h00001, 8'h11, 1, rl, al, fl, ca, cw, cb, wr, to);
        tests_run++; if (drop_b !== 1'b0) begin tests_failed++; $display("FAIL drop_early got=%b exp=0", drop_b); end
        loader_write(19'h10000, 8'h55, 1, rl, al, fl, ca, cw, cb, wr, to);
        tests_run++; if (rl !== -1 || wr !== 0) begin tests_failed++; $display("FAIL drop_no_req got req_lat=%0d writes=%0d exp -1/0", rl, wr); end
        tests_run++; if (al !== 1 || fl !== 1) begin tests_failed++; $display("FAIL drop_ack got rise=%0d fall=%0d exp 1/1", al, fl); end
        tests_run++; if (drop_b !== 1'b1) begin tests_failed++; $display("FAIL drop_flag got=%b exp=1", drop_b); end
        tests_run++; if (csum_b !== 8'h11 || cnt_b !== 20'd2) begin tests_failed++; $display("FAIL drop_progress got csum=%h cnt=%0d exp 11/2", csum_b, cnt_b); end
    endtask

    task automatic test_oe_gate();
        int seen;
        sel = 1'b0;
        do_reset();
        seen = 0;
        @(negedge clk);
        loe = 1'b0; ladr = 19'h00004; lwdat = 8'h99; lwr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (req_a || ack_a || busy_a) seen++;
        end
        lwr = 1'b0; loe = 1'b1;
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL oe_gate got_active=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int rl, al, fl, wr, k; logic [22:0] ca; logic [15:0] cw; logic [1:0] cb; bit to;
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        ladr = 19'h00020; lwdat = 8'h77; lwr = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_a && k < 5);
        tests_run++; if (req_a !== 1'b1) begin tests_failed++; $display("FAIL midrst_req_before got=%b exp=1", req_a); end
        #2 rstn = 1'b0;
        #1;
        tests_run++; if (req_a !== 1'b0 || busy_a !== 1'b0 || ack_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_async got req=%b busy=%b ack=%b exp 0", req_a, busy_a, ack_a); end
        tests_run++; if (adr_a !== 23'd0 || wdat_a !== 16'd0 || be_a !== 2'd0) begin tests_failed++; $display("FAIL midrst_fields got adr=%h wdat=%h be=%b exp 0", adr_a, wdat_a, be_a); end
        @(negedge clk);
        lwr = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        loader_write(19'h00021, 8'h66, 1, rl, al, fl, ca, cw, cb, wr, to);
        tests_run++; if (ca !== 23'h10 || cb !== 2'b10 || cw !== 16'h6666 || wr !== 1) begin tests_failed++; $display("FAIL midrst_fresh got adr=%h be=%b wdat=%h writes=%0d exp 10/10/6666/1", ca, cb, cw, wr); end
        tests_run++; if (cnt_a !== 20'd1 || csum_a !== 8'h66) begin tests_failed++; $display("FAIL midrst_progress got cnt=%0d csum=%h exp 1/66", cnt_a, csum_a); end
    endtask

    task automatic test_loaded();
        int rl, al, fl, wr, seen; logic [22:0] ca; logic [15:0] cw; logic [1:0] cb; bit to;
        sel = 1'b0;
        do_reset();
        loader_write(19'h00000, 8'h42, 1, rl, al, fl, ca, cw, cb, wr, to);
        tests_run++; if (loaded_a !== 1'b0) begin tests_failed++; $display("FAIL loaded_early got=%b exp=0", loaded_a); end
        @(negedge clk);
        ldone = 1'b1;
        @(negedge clk);
        tests_run++; if (loaded_a !== 1'b1 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL loaded_set got loaded=%b busy=%b exp 1/0", loaded_a, busy_a); end
        seen = 0;
        ldone = 1'b0; ladr = 19'h00003; lwdat = 8'hEE; lwr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (req_a || ack_a) seen++;
        end
        lwr = 1'b0;
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL loaded_ignores_wr got_active=%0d exp=0", seen); end
        tests_run++; if (loaded_a !== 1'b1 || cnt_a !== 20'd1 || csum_a !== 8'h42) begin tests_failed++; $display("FAIL loaded_hold got loaded=%b cnt=%0d csum=%h exp 1/1/42", loaded_a, cnt_a, csum_a); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_odd_address();
        test_stream();
        test_drop();
        test_oe_gate();
        test_reset_mid();
        test_loaded();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
